// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_ctrl
// Description : Execute-stage sequencer for an external 8-bit ALU. Accepts
//               one instruction per valid/ready handshake, reads operands from
//               an internal register file, drives registered op/A/B to the
//               ALU, captures result/carry/zero, then writes the result back
//               and updates the flag registers. Sequence: IDLE -> EXEC -> WB.
// Ports       : clk, rst_n (sync, active low)
//               instr_valid/instr_ready, instr_op/rd/ra/rb/imm/use_i
//               alu_op/alu_a/alu_b (to ALU), alu_o/alu_c/alu_z (from ALU)
//               ext_we/ext_waddr/ext_wdata (program load, any state)
//               rd_sel/rd_data (combinational debug read)
//               flag_c/flag_z (flags of last completed instruction)
//               done (one-cycle pulse after writeback)
// Options     : ALU_EXEC_IMM_EN - when defined, instr_use_i selects instr_imm
//               as operand B at accept; otherwise both are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl #(
    parameter int         REG_AW    = 2,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_ra,
    input  logic [REG_AW-1:0] instr_rb,
    input  logic [7:0]        instr_imm,
    input  logic              instr_use_i,
    output logic [3:0]        alu_op,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    input  logic [7:0]        alu_o,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              ext_we,
    input  logic [REG_AW-1:0] ext_waddr,
    input  logic [7:0]        ext_wdata,
    input  logic [REG_AW-1:0] rd_sel,
    output logic [7:0]        rd_data,
    output logic              flag_c,
    output logic              flag_z,
    output logic              done
);

    localparam int         C_NREGS   = 1 << REG_AW;
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_EXEC = 2'd1;
    localparam logic [1:0] C_ST_WB   = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic [7:0]        regs_q [C_NREGS];
    logic [7:0]        regs_d [C_NREGS];
    logic [REG_AW-1:0] rd_q,     rd_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [7:0]        alu_a_q,  alu_a_d;
    logic [7:0]        alu_b_q,  alu_b_d;
    logic [7:0]        res_q,    res_d;
    logic              c_q,      c_d;
    logic              z_q,      z_d;
    logic              flag_c_q, flag_c_d;
    logic              flag_z_q, flag_z_d;
    logic              done_q,   done_d;

    logic              w_accept;
    logic [7:0]        w_opnd_b;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: if (w_accept) state_d = C_ST_EXEC;
            C_ST_EXEC: state_d = C_ST_WB;
            C_ST_WB:   state_d = C_ST_IDLE;
            default:   state_d = C_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready = (state_q == C_ST_IDLE);
        w_accept    = instr_valid && (state_q == C_ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Operand B source
    // ------------------------------------------------------------------
`ifdef ALU_EXEC_IMM_EN
    always_comb begin
        w_opnd_b = instr_use_i ? instr_imm : regs_q[instr_rb];
    end
`else
    logic w_unused_imm;
    assign w_unused_imm = ^{instr_imm, instr_use_i};

    always_comb begin
        w_opnd_b = regs_q[instr_rb];
    end
`endif

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        regs_d   = regs_q;
        rd_d     = rd_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        res_d    = res_q;
        c_d      = c_q;
        z_d      = z_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        done_d   = 1'b0;

        // Operands come from regs_q, so an external write landing on the
        // same edge as the accept is not seen by this instruction.
        if (w_accept) begin
            rd_d     = instr_rd;
            alu_op_d = instr_op;
            alu_a_d  = regs_q[instr_ra];
            alu_b_d  = w_opnd_b;
        end

        if (state_q == C_ST_EXEC) begin
            res_d = alu_o;
            c_d   = alu_c;
            z_d   = alu_z;
        end

        if (ext_we) begin
            regs_d[ext_waddr] = ext_wdata;
        end

        // Writeback is applied after the external write so it takes
        // priority on an address collision.
        if (state_q == C_ST_WB) begin
            regs_d[rd_q] = res_q;
            flag_c_d     = c_q;
            flag_z_d     = z_q;
            done_d       = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < C_NREGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            rd_q     <= '0;
            alu_op_q <= 4'h0;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            res_q    <= 8'h00;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            rd_q     <= rd_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            res_q    <= res_d;
            c_q      <= c_d;
            z_q      <= z_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            done_q   <= done_d;
        end
    end

    assign alu_op  = alu_op_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign flag_c  = flag_c_q;
    assign flag_z  = flag_z_q;
    assign done    = done_q;
    assign rd_data = regs_q[rd_sel];

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_ctrl
// Description : Self-checking bench for alu_exec_ctrl. Provides a reference
//               ALU, a timeline model of the register file, and a scoreboard
//               whose monitor checks every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_ctrl;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd, instr_ra, instr_rb;
    logic [7:0] instr_imm;
    logic       instr_use_i;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_o;
    logic       alu_c, alu_z;
    logic       ext_we;
    logic [1:0] ext_waddr;
    logic [7:0] ext_wdata;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
    logic       flag_c, flag_z, done;

    logic       dbg_en;
    logic [1:0] dbg_sel, mon_sel;
    assign rd_sel = dbg_en ? dbg_sel : mon_sel;

    alu_exec_ctrl #(.REG_AW(2), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra),
        .instr_rb(instr_rb), .instr_imm(instr_imm), .instr_use_i(instr_use_i),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_o(alu_o), .alu_c(alu_c), .alu_z(alu_z),
        .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
        .rd_sel(rd_sel), .rd_data(rd_data),
        .flag_c(flag_c), .flag_z(flag_z), .done(done)
    );

    // Reference ALU: returns {carry, zero, result}
    function automatic logic [9:0] alu_fn(input logic [3:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] o;
        logic       c;
        s = 9'h0; o = 8'h00; c = 1'b0;
        case (op)
            4'b0000: o = a & b;
            4'b0001: o = a | b;
            4'b0010: begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; c = s[8]; end
            4'b0011: begin o = a - b; c = (a < b); end
            4'b0100: o = a ^ b;
            4'b1000: o = (a > b) ? 8'd1 : 8'd0;
            default: begin o = 8'h00; c = 1'b0; end
        endcase
        return {c, (o == 8'h00), o};
    endfunction

    assign {alu_c, alu_z, alu_o} = alu_fn(alu_op, alu_a, alu_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard and model state
    typedef struct { logic [1:0] rd; logic [7:0] val; logic c; logic z; } exp_t;
    typedef struct { int due; logic [1:0] rd; logic [7:0] val; } wb_t;

    exp_t       exp_q[$];
    wb_t        pend[$];
    logic [7:0] m_regs [4];
    int         cyc;
    int         n_checks;
    int         n_errors;
    int         n_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // One clock: advance the model at the edge, then check readiness at
    // the following falling edge and clear single-cycle strobes.
    task automatic step();
        logic [9:0] r;
        logic [7:0] b;
        exp_t       e;
        wb_t        w;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            pend.delete();
            exp_q.delete();
        end else begin
            if (instr_valid && (pend.size() == 0)) begin
                b = m_regs[instr_rb];
`ifdef ALU_EXEC_IMM_EN
                if (instr_use_i) b = instr_imm;
`endif
                r = alu_fn(instr_op, m_regs[instr_ra], b);
                w.due = cyc + 2; w.rd = instr_rd; w.val = r[7:0];
                pend.push_back(w);
                e.rd = instr_rd; e.val = r[7:0]; e.c = r[9]; e.z = r[8];
                exp_q.push_back(e);
            end
            if (ext_we) m_regs[ext_waddr] = ext_wdata;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                m_regs[pend[0].rd] = pend[0].val;
                void'(pend.pop_front());
            end
        end
        cyc++;
        @(negedge clk);
        chk("instr_ready", {31'b0, instr_ready}, {31'b0, (pend.size() == 0)});
        instr_valid = 1'b0;
        ext_we      = 1'b0;
    endtask

    task automatic ext_write(input logic [1:0] a, input logic [7:0] d);
        ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
        step();
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [1:0] rd,
                             input logic [1:0] ra, input logic [1:0] rb,
                             input logic use_i, input logic [7:0] imm);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd;
        instr_ra = ra; instr_rb = rb; instr_use_i = use_i; instr_imm = imm;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [1:0] rd,
                             input logic [1:0] ra, input logic [1:0] rb,
                             input logic use_i, input logic [7:0] imm);
        set_instr(op, rd, ra, rb, use_i, imm);
        step();
        repeat (3) step();
    endtask

    task automatic chk_reg(input string nm, input logic [1:0] a, input logic [7:0] expv);
        dbg_en = 1'b1; dbg_sel = a;
        #1;
        chk(nm, {24'b0, rd_data}, {24'b0, expv});
        dbg_en = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest expected writeback.
    initial begin : p_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL done_unexpected: got done=1 expected no pending writeback (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    mon_sel = e.rd;
                    #1;
                    chk("wb_value", {24'b0, rd_data}, {24'b0, e.val});
                    chk("wb_flag_c", {31'b0, flag_c}, {31'b0, e.c});
                    chk("wb_flag_z", {31'b0, flag_z}, {31'b0, e.z});
                end
            end
        end
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : p_main
        int d0;
        int guard;
        n_checks = 0; n_errors = 0; n_done = 0; cyc = 0;
        rst_n = 1'b0; instr_valid = 1'b0; instr_op = 4'h0;
        instr_rd = 2'd0; instr_ra = 2'd0; instr_rb = 2'd0;
        instr_imm = 8'h00; instr_use_i = 1'b0;
        ext_we = 1'b0; ext_waddr = 2'd0; ext_wdata = 8'h00;
        dbg_en = 1'b0; dbg_sel = 2'd0; mon_sel = 2'd0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

        // Reset
        step(); step();
        rst_n = 1'b1;
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_flag_c", {31'b0, flag_c}, 32'd0);
        chk("rst_flag_z", {31'b0, flag_z}, 32'd0);
        chk("rst_alu_a", {24'b0, alu_a}, 32'd0);
        chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
        for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), 8'h00);

        // ADD 05+03 with latency checks
        ext_write(2'd1, 8'h05);
        ext_write(2'd2, 8'h03);
        set_instr(4'b0010, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
        step();
        chk("alu_a_T1", {24'b0, alu_a}, 32'h05);
        chk("alu_b_T1", {24'b0, alu_b}, 32'h03);
        chk("alu_op_T1", {28'b0, alu_op}, 32'h2);
        step();
        chk("done_T2", {31'b0, done}, 32'd0);
        step();
        chk("done_T3", {31'b0, done}, 32'd1);
        step();
        chk("done_T4", {31'b0, done}, 32'd0);
        chk_reg("add_r0", 2'd0, 8'h08);
        chk("add_c", {31'b0, flag_c}, 32'd0);
        chk("add_z", {31'b0, flag_z}, 32'd0);

        // ADD with carry-out to zero
        ext_write(2'd1, 8'hFF);
        ext_write(2'd2, 8'h01);
        run_instr(4'b0010, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
        chk_reg("addc_r3", 2'd3, 8'h00);
        chk("addc_c", {31'b0, flag_c}, 32'd1);
        chk("addc_z", {31'b0, flag_z}, 32'd1);

        // SUB with borrow, then GT with rd overwriting
        ext_write(2'd1, 8'h03);
        ext_write(2'd2, 8'h05);
        run_instr(4'b0011, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00);
        chk_reg("sub_r1", 2'd1, 8'hFE);
        chk("sub_c", {31'b0, flag_c}, 32'd1);
        run_instr(4'b1000, 2'd3, 2'd2, 2'd1, 1'b0, 8'h00);
        chk_reg("gt_r3", 2'd3, 8'h00);
        chk("gt_z", {31'b0, flag_z}, 32'd1);

        // Undefined opcode still writes back 0
        run_instr(4'b1111, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00);
        chk_reg("undef_r2", 2'd2, 8'h00);
        chk("undef_z", {31'b0, flag_z}, 32'd1);

        // Back-to-back with valid held high
        d0 = n_done;
        set_instr(4'b0010, 2'd0, 2'd1, 2'd1, 1'b0, 8'h00);
        step();
        set_instr(4'b0100, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00);
        step();
        set_instr(4'b0100, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00);
        step();
        set_instr(4'b0100, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00);
        step();
        repeat (5) step();
        chk("b2b_done_count", 32'(n_done - d0), 32'd2);

        // Reset during EXEC drops the instruction
        ext_write(2'd1, 8'h05);
        ext_write(2'd2, 8'h03);
        d0 = n_done;
        set_instr(4'b0010, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstx_done", {31'b0, done}, 32'd0);
        repeat (4) step();
        chk("rstx_no_done", 32'(n_done - d0), 32'd0);
        chk_reg("rstx_r0", 2'd0, 8'h00);
        chk_reg("rstx_r1", 2'd1, 8'h00);

`ifdef ALU_EXEC_IMM_EN
        ext_write(2'd1, 8'h05);
        run_instr(4'b0010, 2'd3, 2'd1, 2'd2, 1'b1, 8'h10);
        chk_reg("imm_r3", 2'd3, 8'h15);
`endif

        // Randomized traffic with concurrent external writes
        for (int k = 0; k < 400; k++) begin
            ext_we      = ($urandom_range(0, 3) == 0);
            ext_waddr   = 2'($urandom_range(0, 3));
            ext_wdata   = 8'($urandom_range(0, 255));
            instr_valid = 1'($urandom_range(0, 1));
            instr_op    = 4'($urandom_range(0, 15));
            instr_rd    = 2'($urandom_range(0, 3));
            instr_ra    = 2'($urandom_range(0, 3));
            instr_rb    = 2'($urandom_range(0, 3));
            instr_imm   = 8'($urandom_range(0, 255));
            instr_use_i = 1'($urandom_range(0, 1));
            step();
        end

        guard = 0;
        while ((pend.size() != 0 || exp_q.size() != 0) && guard < 20) begin
            step();
            guard++;
        end
        step();
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) chk_reg("final_reg", 2'(i), m_regs[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
